// File: rtl/serv_rf_ram_pkg.sv
// Shared types and sizing helpers for the SERV register-file RAM.
// Optional parity storage: define SERV_RF_RAM_PARITY_EN.
package serv_rf_ram_pkg;

    localparam int RF_GPRS = 32;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    function automatic int rf_depth(int width, int csr_regs);
        return 32 * (RF_GPRS + csr_regs) / width;
    endfunction

endpackage

// File: rtl/serv_rf_ram_if.sv
// RF RAM access bundle between the core-side RF interface and the RAM.
// master drives addresses/enables, slave returns data and status.
interface serv_rf_ram_if #(
    parameter int width = 8,
    parameter int aw    = 8
);
    logic [aw-1:0]    waddr;
    logic [width-1:0] wdata;
    logic             wen;
    logic [aw-1:0]    raddr;
    logic             ren;
    logic [width-1:0] rdata;
    logic             ready;
    logic             perr;

    modport master (
        output waddr, wdata, wen, raddr, ren,
        input  rdata, ready, perr
    );

    modport slave (
        input  waddr, wdata, wen, raddr, ren,
        output rdata, ready, perr
    );
endinterface

// File: rtl/serv_rf_ram_core.sv
// Bare storage array with a registered read port.
// The array itself has no reset; only the read register does.
module serv_rf_ram_core #(
    parameter int dw    = 8,
    parameter int depth = 144,
    parameter int aw    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wen,
    input  logic [aw-1:0] i_waddr,
    input  logic [dw-1:0] i_wdata,
    input  logic          i_ren,
    input  logic          i_rvalid,
    input  logic [aw-1:0] i_raddr,
    output logic [dw-1:0] o_rdata
);
    logic [dw-1:0] mem [depth];

    always_ff @(posedge i_clk) begin
        if (i_wen)
            mem[i_waddr] <= i_wdata;
    end

    // Nonblocking read sees the pre-write word: read-before-write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_rdata <= '0;
        else if (i_ren)
            o_rdata <= i_rvalid ? mem[i_raddr] : '0;
    end
endmodule

// File: rtl/serv_rf_ram_clr.sv
// RF RAM with post-reset clear sweep, range checks and optional parity.
// Parity storage enabled by defining SERV_RF_RAM_PARITY_EN.
module serv_rf_ram_clr
    import serv_rf_ram_pkg::*;
#(
    parameter int width          = 8,
    parameter int csr_regs       = 4,
    parameter int depth          = rf_depth(width, csr_regs),
    parameter int aw             = $clog2(depth),
    parameter int clear_on_reset = 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    serv_rf_ram_if.slave rf
);
`ifdef SERV_RF_RAM_PARITY_EN
    localparam int dw = width + 1;
`else
    localparam int dw = width;
`endif

    localparam logic [aw-1:0] LAST   = aw'(depth - 1);
    localparam logic [aw:0]   DEPTHW = (aw + 1)'(depth);
    localparam state_e ST_RST =
        (clear_on_reset != 0) ? ST_CLEAR : ST_READY;

    state_e        state;
    state_e        state_nxt;
    logic [aw-1:0] caddr;
    logic          ready_q;

    logic          mem_we;
    logic [aw-1:0] mem_waddr;
    logic [dw-1:0] mem_wdata;
    logic          mem_ren;
    logic [dw-1:0] wword;
    logic [dw-1:0] rword;
    logic          w_ok;
    logic          r_ok;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_RST;
            caddr   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_READY);
            if (state == ST_CLEAR)
                caddr <= caddr + aw'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == ST_CLEAR):
                if (caddr == LAST)
                    state_nxt = ST_READY;
            default: ;
        endcase
    end

    assign w_ok = ({1'b0, rf.waddr} < DEPTHW);
    assign r_ok = ({1'b0, rf.raddr} < DEPTHW);

`ifdef SERV_RF_RAM_PARITY_EN
    assign wword = {^rf.wdata, rf.wdata};
`else
    assign wword = rf.wdata;
`endif

    // Sweep owns the write port until READY; user traffic is ignored
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = rf.waddr;
        mem_wdata = wword;
        mem_ren   = 1'b0;
        unique case (1'b1)
            (state == ST_CLEAR): begin
                mem_we    = i_rst_n;
                mem_waddr = caddr;
                mem_wdata = '0;
            end
            default: begin
                mem_we  = ready_q & rf.wen & w_ok;
                mem_ren = ready_q & rf.ren;
            end
        endcase
    end

    serv_rf_ram_core #(
        .dw    (dw),
        .depth (depth),
        .aw    (aw)
    ) u_core (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wen    (mem_we),
        .i_waddr  (mem_waddr),
        .i_wdata  (mem_wdata),
        .i_ren    (mem_ren),
        .i_rvalid (r_ok),
        .i_raddr  (rf.raddr),
        .o_rdata  (rword)
    );

    assign rf.rdata = rword[width-1:0];
    assign rf.ready = ready_q;

`ifdef SERV_RF_RAM_PARITY_EN
    assign rf.perr = ^rword;
`else
    assign rf.perr = 1'b0;
`endif
endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// Randomized self-checking bench for serv_rf_ram_clr (width=8, depth=144).
// Parity scenario runs only with SERV_RF_RAM_PARITY_EN defined.
module tb_serv_rf_ram_clr;
    localparam int DEPTH = 144;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [7:0] model [256];

    serv_rf_ram_if #(.width(8), .aw(8)) rf ();

    serv_rf_ram_clr #(
        .width          (8),
        .csr_regs       (4),
        .clear_on_reset (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .rf      (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_read(input logic [7:0] a);
        return (int'(a) < DEPTH) ? model[a] : 8'h00;
    endfunction

    task automatic step(input logic wen, input logic [7:0] wa,
                        input logic [7:0] wd, input logic ren,
                        input logic [7:0] ra);
        rf.wen   = wen;
        rf.waddr = wa;
        rf.wdata = wd;
        rf.ren   = ren;
        rf.raddr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) idle();
        foreach (model[i]) model[i] = 8'h00;
    endtask

    task automatic wait_ready(input string name);
        int cnt;
        rst_n = 1'b1;
        cnt = 0;
        while (!rf.ready && cnt < 1000) begin
            idle();
            cnt++;
        end
        n_tests++;
        if (cnt !== DEPTH) begin
            n_fail++;
            $display("FAIL %s: ready after %0d cycles, required %0d",
                     name, cnt, DEPTH);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (rf.ready !== 1'b0 || rf.rdata !== 8'h00 || rf.perr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: ready=%b rdata=%h perr=%b, required 0/00/0",
                     rf.ready, rf.rdata, rf.perr);
        end
        wait_ready("reset_sweep_len");
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, 8'(a));
            n_tests++;
            if (rf.rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL cleared_word @%0d: got %h, required 00", a, rf.rdata);
            end
        end
    endtask

    task automatic test_write_read();
        step(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00);
        model[8'h10] = 8'hA5;
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
        n_tests++;
        if (rf.rdata !== ref_read(8'h10)) begin
            n_fail++;
            $display("FAIL write_read: got %h, required A5", rf.rdata);
        end
        idle();
        idle();
        n_tests++;
        if (rf.rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_hold: got %h, required A5", rf.rdata);
        end
    endtask

    task automatic test_rbw();
        step(1'b1, 8'h20, 8'h11, 1'b0, 8'h00);
        step(1'b1, 8'h20, 8'h3C, 1'b1, 8'h20);
        n_tests++;
        if (rf.rdata !== 8'h11) begin
            n_fail++;
            $display("FAIL rbw_old: got %h, required 11", rf.rdata);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
        model[8'h20] = 8'h3C;
        n_tests++;
        if (rf.rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL rbw_new: got %h, required 3C", rf.rdata);
        end
    endtask

    task automatic test_out_of_range();
        step(1'b1, 8'd200, 8'h77, 1'b0, 8'h00);
        step(1'b1, 8'd143, 8'h9E, 1'b0, 8'h00);
        model[143] = 8'h9E;
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'd143);
        n_tests++;
        if (rf.rdata !== 8'h9E) begin
            n_fail++;
            $display("FAIL last_word: got %h, required 9E", rf.rdata);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'd200);
        n_tests++;
        if (rf.rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_read: got %h, required 00", rf.rdata);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'd56);
        n_tests++;
        if (rf.rdata !== ref_read(8'd56)) begin
            n_fail++;
            $display("FAIL oor_alias @56: got %h, required %h",
                     rf.rdata, ref_read(8'd56));
        end
    endtask

    task automatic test_random();
        logic [7:0] rexp;
        logic [7:0] wa, wd, ra;
        logic       wen, ren;
        rexp = rf.rdata;
        for (int i = 0; i < 400; i++) begin
            wen = 1'($urandom_range(0, 1));
            ren = 1'($urandom_range(0, 1));
            wa  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 31));
            wd  = 8'($urandom);
            if (ren) rexp = ref_read(ra);
            if (wen && int'(wa) < DEPTH) model[wa] = wd;
            step(wen, wa, wd, ren, ra);
            n_tests++;
            if (rf.rdata !== rexp || rf.perr !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d] ra=%h: got %h perr=%b, required %h perr=0",
                         i, ra, rf.rdata, rf.perr, rexp);
            end
        end
    endtask

    task automatic test_clear_ignore();
        do_reset();
        n_tests++;
        if (rf.rdata !== 8'h00 || rf.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: rdata=%h ready=%b, required 00/0",
                     rf.rdata, rf.ready);
        end
        rst_n = 1'b1;
        repeat (10) idle();
        step(1'b1, 8'h05, 8'hFF, 1'b1, 8'h05);
        n_tests++;
        if (rf.rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_rdata: got %h, required 00", rf.rdata);
        end
        repeat (DEPTH - 11) idle();
        n_tests++;
        if (rf.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_ready: got %b, required 1", rf.ready);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h05);
        n_tests++;
        if (rf.rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_wen_ignored: got %h, required 00", rf.rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        int seen;
        do_reset();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            idle();
            if (rf.ready) seen++;
        end
        rst_n = 1'b0;
        repeat (2) idle();
        n_tests++;
        if (seen != 0 || rf.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_ready: ready seen %0d times, required 0", seen);
        end
        wait_ready("restart_sweep_len");
    endtask

`ifdef SERV_RF_RAM_PARITY_EN
    task automatic test_parity();
        step(1'b1, 8'h30, 8'h5A, 1'b0, 8'h00);
        step(1'b1, 8'h31, 8'h77, 1'b0, 8'h00);
        dut.u_core.mem[8'h30][0] = ~dut.u_core.mem[8'h30][0];
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h30);
        n_tests++;
        if (rf.rdata !== 8'h5B || rf.perr !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_err: got %h perr=%b, required 5B perr=1",
                     rf.rdata, rf.perr);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h31);
        n_tests++;
        if (rf.rdata !== 8'h77 || rf.perr !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_clean: got %h perr=%b, required 77 perr=0",
                     rf.rdata, rf.perr);
        end
    endtask
`endif

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rf.wen   = 1'b0;
        rf.waddr = '0;
        rf.wdata = '0;
        rf.ren   = 1'b0;
        rf.raddr = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_rbw();
        test_out_of_range();
        test_random();
        test_clear_ignore();
        test_reset_mid_clear();
`ifdef SERV_RF_RAM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
